// File: rtl/jtkicker_gfx_pkg.sv
// Shared definitions for the graphics ROM responder: FSM encoding, client ids and
// the default SDRAM region offsets.
package jtkicker_gfx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StBeat0,
    StBeat1
  } gfx_st_e;

  localparam logic CL_SCR = 1'b0;
  localparam logic CL_OBJ = 1'b1;

  localparam logic [21:0] SCR_OFFSET_DEF = 22'h00_0000;
  localparam logic [21:0] OBJ_OFFSET_DEF = 22'h00_4000;

endpackage

// File: rtl/jtkicker_rom_tag.sv
// One-word cache line for a graphics ROM client: held data, tag and valid bit,
// with hit/miss detection against the live client address.
module jtkicker_rom_tag #(
  parameter int unsigned AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          commit_i,
  input  logic [31:0]   word_i,
  input  logic [AW-1:0] tag_i,
  output logic [31:0]   data_o,
  output logic          ok_o,
  output logic          miss_o
);

  logic [31:0]   data_q, data_d;
  logic [AW-1:0] tag_q, tag_d;
  logic          valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (commit_i) begin
      data_d  = word_i;
      tag_d   = tag_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign data_o = data_q;
  assign ok_o   = cs_i & valid_q & (tag_q == addr_i);
  assign miss_o = cs_i & ~ok_o;

endmodule

// File: rtl/jtkicker_gfx_rom.sv
// SDRAM-side responder for the scroll and object graphics ROM clients: arbitrates
// misses, fetches each 32-bit word as two 16-bit beats and commits it to the client.
module jtkicker_gfx_rom
  import jtkicker_gfx_pkg::*;
#(
  parameter logic [21:0] SCR_OFFSET = SCR_OFFSET_DEF,
  parameter logic [21:0] OBJ_OFFSET = OBJ_OFFSET_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [13:0] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [15:0] sdram_din
);

  gfx_st_e     state_q, state_d;
  logic        cl_q, cl_d;
  logic        last_q, last_d;
  logic [13:0] fa_q, fa_d;
  logic        req_q, req_d;
  logic [21:0] addr_q, addr_d;
  logic [15:0] lo_q, lo_d;

  logic        scr_miss, obj_miss, pick;
  logic        scr_commit, obj_commit;
  logic [21:0] scr_sd, obj_sd;
  logic [31:0] word;

  assign scr_sd = SCR_OFFSET + {8'd0, scr_addr, 1'b0};
  assign obj_sd = OBJ_OFFSET + {7'd0, obj_addr, 1'b0};
  assign word   = {sdram_din, lo_q};

  // Round-robin only matters when both miss; otherwise the lone requester wins.
  assign pick = (scr_miss & obj_miss) ? ~last_q : obj_miss;

  always_comb begin
    state_d    = state_q;
    cl_d       = cl_q;
    last_d     = last_q;
    fa_d       = fa_q;
    req_d      = req_q;
    addr_d     = addr_q;
    lo_d       = lo_q;
    scr_commit = 1'b0;
    obj_commit = 1'b0;
    case (state_q)
      StIdle: begin
        if (scr_miss | obj_miss) begin
          cl_d    = pick;
          last_d  = pick;
          fa_d    = (pick == CL_OBJ) ? obj_addr : {1'b0, scr_addr};
          addr_d  = (pick == CL_OBJ) ? obj_sd : scr_sd;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          // A strobe coinciding with the ack is already the low beat.
          state_d = sdram_dst ? StBeat1 : StBeat0;
          if (sdram_dst) lo_d = sdram_din;
        end
      end
      StBeat0: begin
        if (sdram_dst) begin
          lo_d    = sdram_din;
          state_d = StBeat1;
        end
      end
      StBeat1: begin
        if (sdram_dst) begin
          scr_commit = (cl_q == CL_SCR);
          obj_commit = (cl_q == CL_OBJ);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cl_q    <= CL_SCR;
      last_q  <= CL_OBJ;
      fa_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cl_q    <= cl_d;
      last_q  <= last_d;
      fa_q    <= fa_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  jtkicker_rom_tag #(.AW(13)) u_scr (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_i     (1'b1),
    .addr_i   (scr_addr),
    .commit_i (scr_commit),
    .word_i   (word),
    .tag_i    (fa_q[12:0]),
    .data_o   (scr_data),
    .ok_o     (scr_ok),
    .miss_o   (scr_miss)
  );

  jtkicker_rom_tag #(.AW(14)) u_obj (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_i     (obj_cs),
    .addr_i   (obj_addr),
    .commit_i (obj_commit),
    .word_i   (word),
    .tag_i    (fa_q),
    .data_o   (obj_data),
    .ok_o     (obj_ok),
    .miss_o   (obj_miss)
  );

endmodule
